// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M divider.
package mdu_pkg;

   // funct3[1:0] of the DIV/DIVU/REM/REMU group
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_e;

   // Most negative two's-complement value of the given width, right-aligned
   function automatic logic [63:0] min_int(input int unsigned width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rem,
   input  logic [DATA_WIDTH-1:0] quo,
   input  logic [DATA_WIDTH-1:0] dvs,
   output logic [DATA_WIDTH-1:0] step_rem,
   output logic [DATA_WIDTH-1:0] step_quo
);

   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] trial;

   // rem < dvs holds on entry, so trial always fits in DATA_WIDTH+1 signed bits
   always_comb begin
      shifted = {rem, quo[DATA_WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
      if (!trial[DATA_WIDTH]) begin
         step_rem = trial[DATA_WIDTH-1:0];
         step_quo = {quo[DATA_WIDTH-2:0], 1'b1};
      end else begin
         step_rem = shifted[DATA_WIDTH-1:0];
         step_quo = {quo[DATA_WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mdu_div_iter.sv
// Iterative RV32M divider: one quotient bit per cycle, 1-cycle fast path for
// divide-by-zero and signed overflow, sign fix-up in a final FIX cycle.
module mdu_div_iter
   import mdu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [DATA_WIDTH-1:0] MIN_INT = DATA_WIDTH'(min_int(DATA_WIDTH));

   state_e                state, state_nx;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] rem, quo, dvs;
   logic                  sel_rem, neg_q, neg_r;

   logic                  accept, is_signed, sign_a, sign_b;
   logic                  div_zero, overflow, cnt_last;
   logic [DATA_WIDTH-1:0] abs_a, abs_b;
   logic [DATA_WIDTH-1:0] step_rem, step_quo;
   logic [DATA_WIDTH-1:0] quo_fix, rem_fix;

   div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .dvs      (dvs),
      .step_rem (step_rem),
      .step_quo (step_quo)
   );

   // Acceptance decode, operand magnitudes and fast-path detection
   always_comb begin
      accept    = (state == IDLE) && start && !flush;
      is_signed = (op == OP_DIV) || (op == OP_REM);
      sign_a    = is_signed && dividend[DATA_WIDTH-1];
      sign_b    = is_signed && divisor[DATA_WIDTH-1];
      abs_a     = sign_a ? -dividend : dividend;
      abs_b     = sign_b ? -divisor : divisor;
      div_zero  = (divisor == '0);
      overflow  = is_signed && (dividend == MIN_INT) && (divisor == '1);
      cnt_last  = (cnt == CNT_W'(1));
      busy      = (state != IDLE);
      quo_fix   = neg_q ? -quo : quo;
      rem_fix   = neg_r ? -rem : rem;
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (div_zero || overflow) ? FIX : CALC;
         CALC:    if (cnt_last) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   // Operand capture and iteration; fast path preloads the final value with
   // sign flags cleared so FIX passes it through untouched
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         sel_rem <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else if (accept) begin
         sel_rem <= op[1];
         cnt     <= CNT_W'(DATA_WIDTH);
         dvs     <= abs_b;
         if (div_zero) begin
            quo   <= '1;
            rem   <= dividend;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
         end else if (overflow) begin
            quo   <= MIN_INT;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
         end else begin
            quo   <= abs_a;
            rem   <= '0;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
         end
      end else if ((state == CALC) && !flush) begin
         rem <= step_rem;
         quo <= step_quo;
         cnt <= cnt - 1'b1;
      end
   end

   // Result and done pulse, produced on leaving FIX
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= (state == FIX) && !flush;
         if ((state == FIX) && !flush) result <= sel_rem ? rem_fix : quo_fix;
      end
   end

endmodule

// File: tb/tb_mdu_div_iter.sv
// Self-checking bench for mdu_div_iter: vector table, hand-written corner
// sequences and a randomized run against a RISC-V division reference model.
module tb_mdu_div_iter;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rstn, start, flush;
   logic [1:0]  op;
   logic [31:0] dividend, divisor;
   logic        busy, done;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   localparam logic [31:0] MINV = 32'h8000_0000;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;
   vec_t vecs[$];

   mdu_div_iter #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic ovf;
      ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
      case (o)
         OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? MINV : 32'($signed(a) / $signed(b));
         OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return MINV;
         4: return 32'($urandom_range(0, 300));
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard: every done pulse consumes one expected result
   always @(negedge clk) begin
      if (rstn && done) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got=0x%08h want=no done", result);
         end else begin
            chk("result", result, exp_q.pop_front());
            chk("busy_in_done", {31'b0, busy}, 32'h0);
         end
      end
   end

   // Drive a request in the current cycle; returns one cycle after the accept edge
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
      op = o; dividend = a; divisor = b; start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      dividend = ~a;
      divisor  = ~b;
   endtask

   // Cycle index counts the request cycle as 0; flush_at<0 disables the flush
   task automatic wait_done(input int lat0, input int flush_at, output int lat, output int bc, output bit aborted);
      lat = lat0; bc = 0; aborted = 1'b0;
      forever begin
         if (done) break;
         if (lat >= 100) begin
            total++;
            bad++;
            $display("FAIL timeout: got=no done after %0d cycles want=done", lat);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            break;
         end
         if (busy) bc++;
         if (lat == flush_at) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            aborted = 1'b1;
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: got=no finish want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat, bc, nd;
      bit  ab;
      logic [1:0]  ro;
      logic [31:0] ra, rb, re;
      int  fa;
      bit  fast;

      rstn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
      #12;
      chk("reset_busy", {31'b0, busy}, 32'h0);
      chk("reset_done", {31'b0, done}, 32'h0);
      chk("reset_result", result, 32'h0);
      @(negedge clk); rstn = 1'b1;

      vecs.push_back('{OP_DIVU, 32'd100,        32'd7,        32'd14,        34});
      vecs.push_back('{OP_REMU, 32'd100,        32'd7,        32'd2,         34});
      vecs.push_back('{OP_DIV,  32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 34});
      vecs.push_back('{OP_REM,  32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 34});
      vecs.push_back('{OP_REM,  32'd100,        32'hFFFF_FFF9, 32'd2,         34});
      vecs.push_back('{OP_DIV,  32'd5,          32'd0,        32'hFFFF_FFFF, 2});
      vecs.push_back('{OP_REM,  32'h1234,       32'd0,        32'h1234,      2});
      vecs.push_back('{OP_DIVU, 32'd7,          32'd0,        32'hFFFF_FFFF, 2});
      vecs.push_back('{OP_REMU, MINV,           32'd0,        MINV,          2});
      vecs.push_back('{OP_DIV,  MINV,           32'hFFFF_FFFF, MINV,          2});
      vecs.push_back('{OP_REM,  MINV,           32'hFFFF_FFFF, 32'h0,         2});
      vecs.push_back('{OP_DIVU, MINV,           32'hFFFF_FFFF, 32'h0,         34});
      vecs.push_back('{OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         34});
      vecs.push_back('{OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34});
      vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 34});
      vecs.push_back('{OP_DIV,  MINV,           32'd1,        MINV,          34});
      vecs.push_back('{OP_REM,  MINV,           32'd3,        32'hFFFF_FFFE, 34});
      vecs.push_back('{OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         34});

      foreach (vecs[i]) begin
         @(negedge clk);
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
         wait_done(1, -1, lat, bc, ab);
         chk($sformatf("latency[%0d]", i), lat, vecs[i].lat);
         chk($sformatf("busy_cycles[%0d]", i), bc, vecs[i].lat - 1);
      end

      // start while busy is ignored
      @(negedge clk);
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
      repeat (5) begin @(posedge clk); #1; end
      op = OP_DIV; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done(7, -1, lat, bc, ab);
      chk("busy_start_latency", lat, 34);
      // back-to-back: start in the done cycle
      issue(OP_REMU, 32'd100, 32'd7, 32'd2);
      wait_done(1, -1, lat, bc, ab);
      chk("b2b_latency", lat, 34);
      repeat (40) @(posedge clk);
      chk("busy_start_queue", exp_q.size(), 0);

      // flush mid-CALC
      @(negedge clk);
      issue(OP_DIVU, 32'hFFFF, 32'd3, 32'h5555);
      wait_done(1, 10, lat, bc, ab);
      chk("flush_busy", {31'b0, busy}, 32'h0);
      chk("flush_result", result, 32'd2);
      nd = 0;
      repeat (40) begin @(posedge clk); #1; if (done) nd++; end
      chk("flush_no_done", nd, 0);
      @(negedge clk);
      issue(OP_DIVU, 32'hFFFF, 32'd3, 32'h5555);
      wait_done(1, -1, lat, bc, ab);
      chk("after_flush_latency", lat, 34);
      // flush in the done cycle: done stands, result holds
      flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      chk("flush_done_busy", {31'b0, busy}, 32'h0);
      chk("flush_done_result", result, 32'h5555);
      // flush together with start: start dropped
      @(negedge clk);
      op = OP_DIVU; dividend = 32'd9; divisor = 32'd2; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1; start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", {31'b0, busy}, 32'h0);
      repeat (5) @(posedge clk);

      // async reset mid-CALC
      @(negedge clk);
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
      repeat (10) begin @(posedge clk); #1; end
      #2 rstn = 1'b0;
      #1;
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_result", result, 32'h0);
      exp_q.delete();
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);
      issue(OP_REMU, 32'd100, 32'd7, 32'd2);
      wait_done(1, -1, lat, bc, ab);
      chk("after_rst_latency", lat, 34);

      // randomized run with occasional flush
      for (int n = 0; n < 1200; n++) begin
         ro = 2'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         re = ref_model(ro, ra, rb);
         fa = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 36)) : -1;
         fast = (rb == 0) || (!ro[0] && ra == MINV && rb == 32'hFFFF_FFFF);
         @(negedge clk);
         issue(ro, ra, rb, re);
         wait_done(1, fa, lat, bc, ab);
         if (ab) chk("rand_flush_busy", {31'b0, busy}, 32'h0);
         else    chk("rand_latency", lat, fast ? 2 : 34);
      end
      repeat (3) @(posedge clk);
      chk("final_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
